// File: rtl/mcu_spi_bridge_if.sv
// mcu_spi_bridge_if: SPI pins and target byte bus of the MCU SPI bridge.
//   spi_ss_n, spi_sclk, spi_mosi : MCU -> bridge (asynchronous to clk)
//   spi_miso                     : bridge -> MCU
//   tgt_strobe[NUM_TGT]          : one-hot, one-clk pulse per delivered byte
//   tgt_start                    : qualifies tgt_strobe as a command byte
//   tgt_data[8]                  : byte delivered with tgt_strobe
//   tgt_dout[8*NUM_TGT]          : data_out of each target, target n in [8n+7:8n]
//   busy                         : a frame is in progress
// Modports: master = MCU / target side, slave = bridge.
interface mcu_spi_bridge_if #(
  parameter int NUM_TGT = 3
);
  logic                 spi_ss_n;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic [NUM_TGT-1:0]   tgt_strobe;
  logic                 tgt_start;
  logic [7:0]           tgt_data;
  logic [8*NUM_TGT-1:0] tgt_dout;
  logic                 busy;

  modport master (
    output spi_ss_n, spi_sclk, spi_mosi, tgt_dout,
    input  spi_miso, tgt_strobe, tgt_start, tgt_data, busy
  );

  modport slave (
    input  spi_ss_n, spi_sclk, spi_mosi, tgt_dout,
    output spi_miso, tgt_strobe, tgt_start, tgt_data, busy
  );
endinterface

// File: rtl/mcu_spi_bridge.sv
// mcu_spi_bridge: SPI mode-0 slave toward the board MCU. Each frame is
// <selector> <command> <payload...>; command and payload bytes are delivered
// as one-clk strobes to the selected target, and the selected target's
// data_out byte is shifted back on MISO with one byte of read latency.
// Ports:
//   clk   : system clock, >= 4x SCLK (>= 6x with the glitch filter)
//   reset : synchronous, active-high
//   bus   : mcu_spi_bridge_if.slave (SPI pins, target strobes/data, busy)
// Parameters: SYNC_STAGES (2..3) synchronizer depth, NUM_TGT target count.
// Build option: define MCU_SPI_GLITCH_FILTER_EN to pass the synchronized
// SCLK through a 3-sample majority filter (+1 clk latency on strobe and MISO).
module mcu_spi_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_TGT     = 3
) (
  input logic            clk,
  input logic            reset,
  mcu_spi_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEL, CMD, DATA} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                 ss_s, sclk_s, mosi_s;
  logic                 sclk_use, mosi_use;
  logic                 ss_prev, sclk_prev;
  logic                 sclk_rise, sclk_fall, ss_fall;
  logic [2:0]           bit_cnt;
  logic [6:0]           rx_shift;
  logic [7:0]           rx_next;
  logic [7:0]           tx_shift, tx_next, dout_sel;
  logic [7:0]           sel;
  logic [NUM_TGT-1:0]   sel_hot;
  logic                 first_fall;
  logic                 miso_q, start_q, busy_q;
  logic [NUM_TGT-1:0]   strobe_q;
  logic [7:0]           data_q;

  // Input synchronizers
  always_ff @(posedge clk) begin
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   bus.spi_ss_n};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

`ifdef MCU_SPI_GLITCH_FILTER_EN
  // Majority of the current and two previous samples; MOSI is delayed by one
  // clk so it stays aligned with the filtered SCLK.
  logic sclk_h1, sclk_h2, mosi_d;

  always_ff @(posedge clk) begin
    sclk_h1 <= sclk_s;
    sclk_h2 <= sclk_h1;
    mosi_d  <= mosi_s;
  end

  assign sclk_use = (sclk_s & sclk_h1) | (sclk_s & sclk_h2) | (sclk_h1 & sclk_h2);
  assign mosi_use = mosi_d;
`else
  assign sclk_use = sclk_s;
  assign mosi_use = mosi_s;
`endif

  assign sclk_rise = sclk_use & ~sclk_prev;
  assign sclk_fall = ~sclk_use & sclk_prev;
  // ss_prev resets low, so a frame already in progress at reset release is
  // never mistaken for a new one: a genuine high-to-low transition is required.
  assign ss_fall   = ss_prev & ~ss_s;

  // Target decode: an out-of-range selector yields no strobe and a zero byte.
  always_comb begin
    rx_next  = {rx_shift, mosi_use};
    dout_sel = '0;
    sel_hot  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel == 8'(i)) begin
        dout_sel   = bus.tgt_dout[8*i +: 8];
        sel_hot[i] = 1'b1;
      end
    end
    // The falling edge that follows a completed byte loads the next reply byte;
    // the very first falling edge of a frame never loads.
    if (bit_cnt == 3'd0 && !first_fall) tx_next = dout_sel;
    else                                tx_next = {tx_shift[6:0], 1'b0};
  end

  // Receive shift register
  always_ff @(posedge clk) begin
    if (state != IDLE && sclk_rise) rx_shift <= rx_next[6:0];
  end

  // Frame FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      sel        <= 8'(NUM_TGT);
      first_fall <= 1'b0;
      ss_prev    <= 1'b0;
      sclk_prev  <= 1'b0;
      miso_q     <= 1'b0;
      strobe_q   <= '0;
      start_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      ss_prev   <= ss_s;
      sclk_prev <= sclk_use;
      strobe_q  <= '0;
      start_q   <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (ss_fall) begin
            state      <= SEL;
            busy_q     <= 1'b1;
            tx_shift   <= '0;
            miso_q     <= 1'b0;
            sel        <= 8'(NUM_TGT);
            first_fall <= 1'b1;
          end
        end
        default: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == SEL) begin
                sel   <= rx_next;
                state <= CMD;
              end else begin
                if (|sel_hot) begin
                  strobe_q <= sel_hot;
                  start_q  <= (state == CMD);
                  data_q   <= rx_next;
                end
                state <= DATA;
              end
            end
          end
          if (sclk_fall) begin
            tx_shift   <= tx_next;
            miso_q     <= tx_next[7];
            first_fall <= 1'b0;
          end
          // Placed last so it overrides the state update above while still
          // letting a byte completed in this same clk emit its strobe.
          if (ss_s) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.spi_miso   = miso_q;
  assign bus.tgt_strobe = strobe_q;
  assign bus.tgt_start  = start_q;
  assign bus.tgt_data   = data_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// tb_mcu_spi_bridge: directed bench for mcu_spi_bridge. Acts as the SPI
// master, models three targets (sysctrl reply sequence, fixed HID byte,
// SD that echoes the inverted last byte) and checks strobes and MISO bytes.
module tb_mcu_spi_bridge;
  localparam int NUM_TGT = 3;
  localparam int HALF    = 6;   // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mcu_spi_bridge_if #(.NUM_TGT(NUM_TGT)) bus ();

  mcu_spi_bridge #(.SYNC_STAGES(2), .NUM_TGT(NUM_TGT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] tgt;
    logic       start;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int          n;
    logic [39:0] tx;
    logic [2:0]  tgt;
    logic [39:0] miso;
  } vec_t;

  ev_t  evq[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_err = 0;

  // Target models
  localparam logic [7:0] HID_DOUT = 8'h3A;
  logic [7:0] sys_resp [4] = '{8'h5C, 8'h42, 8'h00, 8'h00};
  logic [7:0] sys_dout = 8'h00;
  logic [7:0] sd_dout  = 8'h11;
  int         sys_idx  = 0;

  assign bus.tgt_dout = {sd_dout, HID_DOUT, sys_dout};

  always @(negedge clk) begin
    if (!reset && bus.tgt_strobe != '0) begin
      evq.push_back('{bus.tgt_strobe, bus.tgt_start, bus.tgt_data});
      if (bus.tgt_strobe[0]) begin
        sys_idx  = bus.tgt_start ? 0 : ((sys_idx < 3) ? sys_idx + 1 : 3);
        sys_dout = sys_resp[sys_idx];
      end
      if (bus.tgt_strobe[2]) sd_dout = ~bus.tgt_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    @(negedge clk);
    bus.spi_ss_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_high();
    wait_clk(HALF);
    bus.spi_ss_n = 1'b1;
    wait_clk(4 * HALF);
  endtask

  // Shifts the top nbits of b out MSB first; m collects MISO sampled before each rise.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      wait_clk(HALF);
      m = {m[6:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      wait_clk(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  // Bytes 1..n-1 of tx must appear as strobes to tgt (none if tgt is 0).
  task automatic check_events(input string tag, input logic [2:0] tgt,
                              input logic [39:0] tx, input int n);
    int nexp;
    nexp = (tgt != 3'b000) ? n - 1 : 0;
    chk({tag, " count"}, 32'(evq.size()), 32'(nexp));
    for (int k = 0; k < nexp && k < evq.size(); k++) begin
      chk($sformatf("%s strobe%0d", tag, k), 32'(evq[k].tgt), 32'(tgt));
      chk($sformatf("%s start%0d", tag, k), 32'(evq[k].start), 32'(k == 0));
      chk($sformatf("%s data%0d", tag, k), 32'(evq[k].data), 32'(tx[31-8*k -: 8]));
    end
    evq.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " miso"},   32'(bus.spi_miso),   32'd0);
    chk({tag, " strobe"}, 32'(bus.tgt_strobe), 32'd0);
    chk({tag, " start"},  32'(bus.tgt_start),  32'd0);
    chk({tag, " data"},   32'(bus.tgt_data),   32'd0);
    chk({tag, " busy"},   32'(bus.busy),       32'd0);
  endtask

  initial begin
    logic [7:0] m;

    vecs[0] = '{5, 40'h00_00_00_00_00, 3'b001, 40'h00_00_5C_42_00};
    vecs[1] = '{3, 40'h00_01_03_00_00, 3'b001, 40'h00_00_5C_00_00};
    vecs[2] = '{3, 40'h02_05_AA_00_00, 3'b100, 40'h00_11_FA_00_00};
    vecs[3] = '{3, 40'h07_04_11_00_00, 3'b000, 40'h00_00_00_00_00};
    vecs[4] = '{3, 40'h01_20_30_00_00, 3'b010, 40'h00_3A_3A_00_00};

    bus.spi_ss_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    reset = 1'b1;
    wait_clk(6);
    reset = 1'b0;
    wait_clk(2);
    check_idle_outputs("reset");

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      evq.delete();
      ss_low();
      for (int k = 0; k < vecs[v].n; k++) begin
        xfer(vecs[v].tx[39-8*k -: 8], 8, m);
        chk($sformatf("v%0d miso%0d", v, k), 32'(m), 32'(vecs[v].miso[39-8*k -: 8]));
      end
      ss_high();
      check_events($sformatf("v%0d", v), vecs[v].tgt, vecs[v].tx, vecs[v].n);
    end

    // Selector-only frame
    ss_low();
    xfer(8'h01, 8, m);
    ss_high();
    check_events("selonly", 3'b010, 40'h01_00_00_00_00, 1);

    // SS_N raised after 5 bits of byte 3, then a clean frame
    ss_low();
    chk("busy in frame", 32'(bus.busy), 32'd1);
    xfer(8'h00, 8, m);
    xfer(8'h01, 8, m);
    xfer(8'hF8, 5, m);
    ss_high();
    chk("busy after frame", 32'(bus.busy), 32'd0);
    check_events("partial", 3'b001, 40'h00_01_00_00_00, 2);
    ss_low();
    xfer(8'h00, 8, m);
    xfer(8'h03, 8, m);
    ss_high();
    check_events("after partial", 3'b001, 40'h00_03_00_00_00, 2);

    // Reset during byte 2, released with SS_N still low
    ss_low();
    xfer(8'h00, 8, m);
    xfer(8'h55, 4, m);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    xfer(8'h50, 4, m);
    xfer(8'h66, 8, m);
    wait_clk(2);
    chk("rst frame events", 32'(evq.size()), 32'd0);
    check_idle_outputs("rst mid");
    ss_high();
    check_events("rst tail", 3'b000, 40'h00_55_66_00_00, 3);
    ss_low();
    xfer(8'h00, 8, m);
    xfer(8'h07, 8, m);
    ss_high();
    check_events("after rst", 3'b001, 40'h00_07_00_00_00, 2);

    // SS_N rises one clk after the 8th rising edge: strobe must still appear
    ss_low();
    xfer(8'h00, 8, m);
    xfer(8'h09, 7, m);
    bus.spi_mosi = 1'b1;
    wait_clk(HALF);
    bus.spi_sclk = 1'b1;
    wait_clk(1);
    bus.spi_ss_n = 1'b1;
    wait_clk(HALF);
    bus.spi_sclk = 1'b0;
    wait_clk(4 * HALF);
    check_events("pending", 3'b001, 40'h00_09_00_00_00, 2);
    chk("pending busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
